// File: rtl/fft_pkg.sv
// Shared widths and word types for the FFT core and its downstream consumers.
package fft_pkg;
    localparam int IWIDTH = 22;
    localparam int LGSIZE = 11;
    localparam int MWIDTH = 2 * IWIDTH;

    typedef struct packed {
        logic signed [IWIDTH-1:0] re;
        logic signed [IWIDTH-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic [LGSIZE-1:0] bin;
        logic [MWIDTH-1:0] mag;
    } peak_t;
endpackage

// File: rtl/fft_peak_finder_if.sv
// FFT output stream into the peak finder plus the peak result valid/ready port.
interface fft_peak_finder_if;
    import fft_pkg::*;

    logic              ce;
    logic              sync;
    cplx_t             result;
    logic              valid;
    logic              ready;
    logic [LGSIZE-1:0] bin;
    logic [MWIDTH-1:0] mag;
    logic              drop;

    modport master (output ce, sync, result, ready, input valid, bin, mag, drop);
    modport slave  (input ce, sync, result, ready, output valid, bin, mag, drop);
endinterface

// File: rtl/cmag_sq.sv
// Two-stage CE-gated |X|^2 pipeline; valid and bin index ride alongside the data.
module cmag_sq
    import fft_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_ce,
    input  logic              i_vld,
    input  logic [LGSIZE-1:0] i_bin,
    input  cplx_t             i_x,
    output logic              o_vld,
    output logic [LGSIZE-1:0] o_bin,
    output logic [MWIDTH-1:0] o_sum
);
    logic signed [MWIDTH-1:0] w_re_x, w_im_x, w_re2, w_im2;
    logic        [2:1]        r_vld_pipe;
    logic [LGSIZE-1:0]        r_bin1, r_bin2;
    logic [MWIDTH-1:0]        r_re2, r_im2, r_sum;

    // Squares of signed values are non-negative and at most 2^42, so the
    // low MWIDTH bits of the widened product are exact.
    assign w_re_x = MWIDTH'(i_x.re);
    assign w_im_x = MWIDTH'(i_x.im);
    assign w_re2  = w_re_x * w_re_x;
    assign w_im2  = w_im_x * w_im_x;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_vld_pipe <= '0;
            r_bin1     <= '0;
            r_bin2     <= '0;
            r_re2      <= '0;
            r_im2      <= '0;
            r_sum      <= '0;
        end else if (i_ce) begin
            r_vld_pipe <= {r_vld_pipe[1], i_vld};
            r_bin1     <= i_bin;
            r_bin2     <= r_bin1;
            r_re2      <= w_re2;
            r_im2      <= w_im2;
            r_sum      <= r_re2 + r_im2;
        end
    end

    assign o_vld = r_vld_pipe[2];
    assign o_bin = r_bin2;
    assign o_sum = r_sum;
endmodule

// File: rtl/fft_peak_finder.sv
// Per-frame peak |X|^2 search over a bin window, reported on a valid/ready port.
module fft_peak_finder
    import fft_pkg::*;
#(
    parameter int BIN_LO = 1,
    parameter int BIN_HI = 1023
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    fft_peak_finder_if.slave   bus
);
    localparam logic [LGSIZE-1:0] LO = LGSIZE'(BIN_LO);
    localparam logic [LGSIZE-1:0] HI = LGSIZE'(BIN_HI);

    logic              r_started, r_empty, r_valid, r_drop;
    logic [LGSIZE-1:0] r_cnt, w_bin, w_s2_bin;
    logic              w_in_vld, w_s2_vld, w_act, w_first, w_base_empty;
    logic              w_in_win, w_take, w_next_empty, w_fin, w_free;
    logic [MWIDTH-1:0] w_s2_sum;
    peak_t             r_best, r_out, w_base, w_next;

    // Nothing enters the pipeline until the first synced bin 0.
    assign w_in_vld = bus.ce && (r_started || bus.sync);
    assign w_bin    = bus.sync ? '0 : r_cnt + 1'b1;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_started <= 1'b0;
            r_cnt     <= '0;
        end else if (w_in_vld) begin
            r_started <= 1'b1;
            r_cnt     <= w_bin;
        end
    end

    cmag_sq u_cmag (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_ce      (bus.ce),
        .i_vld     (w_in_vld),
        .i_bin     (w_bin),
        .i_x       (bus.result),
        .o_vld     (w_s2_vld),
        .o_bin     (w_s2_bin),
        .o_sum     (w_s2_sum)
    );

    // Bin 0 restarts the search; the last bin finalizes with its own update folded in.
    always_comb begin
        w_act        = bus.ce && w_s2_vld;
        w_first      = (w_s2_bin == '0);
        w_base_empty = w_first || r_empty;
        w_base       = w_first ? '0 : r_best;
        w_in_win     = (w_s2_bin >= LO) && (w_s2_bin <= HI);
        w_take       = w_in_win && (w_base_empty || (w_s2_sum > w_base.mag));
        w_next       = w_base;
        if (w_take) begin
            w_next.bin = w_s2_bin;
            w_next.mag = w_s2_sum;
        end
        w_next_empty = w_base_empty && !w_take;
        w_fin        = w_act && (w_s2_bin == '1);
        w_free       = !r_valid || bus.ready;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_best  <= '0;
            r_empty <= 1'b1;
        end else if (w_act) begin
            r_best  <= w_next;
            r_empty <= w_next_empty;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_valid <= 1'b0;
            r_out   <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_drop <= w_fin && !w_free;
            if (w_fin && w_free) begin
                r_out   <= w_next;
                r_valid <= 1'b1;
            end else if (bus.ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.valid = r_valid;
    assign bus.bin   = r_out.bin;
    assign bus.mag   = r_out.mag;
    assign bus.drop  = r_drop;
endmodule

// File: tb/tb_fft_peak_finder.sv
// Scoreboard bench for fft_peak_finder: frames in, expected peaks queued, monitor compares.
module tb_fft_peak_finder;
    import fft_pkg::*;

    localparam int N  = 2048;
    localparam int LO = 1;
    localparam int HI = 1023;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft_peak_finder_if bus ();

    fft_peak_finder #(.BIN_LO(LO), .BIN_HI(HI)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    int    checks = 0;
    int    errors = 0;
    int    drop_cnt = 0;
    int    exp_drops = 0;
    peak_t exp_q[$];
    logic signed [IWIDTH-1:0] fr_re[N];
    logic signed [IWIDTH-1:0] fr_im[N];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Reference: largest re^2+im^2 over the window, lowest bin wins ties.
    function automatic peak_t ref_peak();
        peak_t  r;
        longint bm = -1;
        longint m;
        int     bb = LO;
        for (int b = LO; b <= HI; b++) begin
            m = longint'(fr_re[b]) * longint'(fr_re[b]) + longint'(fr_im[b]) * longint'(fr_im[b]);
            if (m > bm) begin
                bm = m;
                bb = b;
            end
        end
        r.bin = LGSIZE'(bb);
        r.mag = MWIDTH'(bm);
        return r;
    endfunction

    task automatic clear_frame();
        for (int b = 0; b < N; b++) begin
            fr_re[b] = '0;
            fr_im[b] = '0;
        end
    endtask

    task automatic rand_frame(input int mode);
        int t;
        int pk;
        for (int b = 0; b < N; b++) begin
            if (mode == 0) begin
                fr_re[b] = IWIDTH'($urandom);
                fr_im[b] = IWIDTH'($urandom);
            end else begin
                t = int'($urandom_range(0, 30)) - 15;
                fr_re[b] = IWIDTH'(t);
                t = int'($urandom_range(0, 30)) - 15;
                fr_im[b] = IWIDTH'(t);
            end
        end
        if (mode != 0) begin
            pk = int'($urandom_range(LO, HI));
            t  = int'($urandom_range(1000, 2000000));
            fr_re[pk] = IWIDTH'(t);
            pk = int'($urandom_range(LO, HI));
            fr_im[pk] = IWIDTH'(-t);
        end
    endtask

    task automatic send_frame(input int n, input bit exp_out, input int gap);
        for (int k = 0; k < n; k++) begin
            repeat (gap) begin
                @(posedge clk); #1;
                bus.ce = 1'b0; bus.sync = 1'b0;
            end
            @(posedge clk); #1;
            bus.ce = 1'b1;
            bus.sync = (k == 0);
            bus.result.re = fr_re[k];
            bus.result.im = fr_im[k];
        end
        if (n == N) begin
            if (exp_out) exp_q.push_back(ref_peak());
            else exp_drops++;
        end
    endtask

    task automatic flush(input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            repeat (gap) begin
                @(posedge clk); #1;
                bus.ce = 1'b0; bus.sync = 1'b0;
            end
            @(posedge clk); #1;
            bus.ce = 1'b1; bus.sync = 1'b0; bus.result = '0;
        end
        @(posedge clk); #1;
        bus.ce = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 20000) begin
            @(posedge clk);
            t++;
        end
        chk("drain", longint'(exp_q.size()), 0);
    endtask

    // Monitor: pops on every accepted result, checks hold stability under backpressure.
    initial begin
        bit    held;
        peak_t hv, e;
        held = 1'b0;
        hv = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
                continue;
            end
            if (bus.drop) drop_cnt++;
            if (held) begin
                chk("hold_valid", longint'(bus.valid), 1);
                chk("hold_bin", longint'(bus.bin), longint'(hv.bin));
                chk("hold_mag", longint'(bus.mag), longint'(hv.mag));
            end
            if (bus.valid && bus.ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got bin %0d mag %0d, required no output", bus.bin, bus.mag);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_bin", longint'(bus.bin), longint'(e.bin));
                    chk("out_mag", longint'(bus.mag), longint'(e.mag));
                end
            end
            held = bus.valid && !bus.ready;
            hv.bin = bus.bin;
            hv.mag = bus.mag;
        end
    end

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ce = 1'b0; bus.sync = 1'b0; bus.result = '0; bus.ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", longint'(bus.valid), 0);
        chk("rst_drop", longint'(bus.drop), 0);
        chk("rst_bin", longint'(bus.bin), 0);
        chk("rst_mag", longint'(bus.mag), 0);
        rst_n = 1'b1;

        // Single tone, with latency from the last bin
        clear_frame();
        fr_re[300] = 22'sd1000; fr_im[300] = -22'sd1000;
        send_frame(N, 1'b1, 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            bus.ce = 1'b1; bus.sync = 1'b0; bus.result = '0;
            chk("latency_valid", longint'(bus.valid), (c == 2) ? 1 : 0);
        end
        flush(2, 0);
        wait_drain();

        // Window edges and tie keeping the lowest bin
        clear_frame();
        fr_re[0] = 22'sd500; fr_im[40] = 22'sd500; fr_re[1500] = 22'sd500; fr_re[900] = -22'sd500;
        send_frame(N, 1'b1, 0);
        flush(4, 0);
        wait_drain();

        // Full scale, magnitude 2^43
        clear_frame();
        fr_re[10] = 22'sh200000; fr_im[10] = 22'sh200000;
        send_frame(N, 1'b1, 0);
        flush(4, 0);
        wait_drain();

        // Backpressure across two frames
        bus.ready = 1'b0;
        rand_frame(1);
        send_frame(N, 1'b1, 0);
        rand_frame(0);
        send_frame(N, 1'b0, 0);
        flush(4, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("bp_drops", longint'(drop_cnt), longint'(exp_drops));
        chk("bp_valid", longint'(bus.valid), 1);
        bus.ready = 1'b1;
        wait_drain();
        #1;
        chk("accept_fall", longint'(bus.valid), 0);

        // Early sync truncates a frame
        clear_frame();
        fr_re[200] = 22'sd3000;
        send_frame(1000, 1'b0, 0);
        clear_frame();
        fr_im[700] = 22'sd2500;
        send_frame(N, 1'b1, 0);
        flush(4, 0);
        wait_drain();
        chk("early_drops", longint'(drop_cnt), longint'(exp_drops));

        // Sparse CE, 1 in 3
        clear_frame();
        fr_re[300] = 22'sd1000; fr_im[300] = -22'sd1000;
        send_frame(N, 1'b1, 2);
        rand_frame(1);
        send_frame(N, 1'b1, 2);
        flush(4, 2);
        wait_drain();

        // Back-to-back random frames, zero bubble
        for (int f = 0; f < 4; f++) begin
            rand_frame(f % 2);
            send_frame(N, 1'b1, 0);
        end
        flush(4, 0);
        wait_drain();

        // Reset in mid-frame
        bus.ready = 1'b0;
        rand_frame(1);
        send_frame(N, 1'b1, 0);
        flush(4, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_valid", longint'(bus.valid), 1);
        rand_frame(1);
        send_frame(1500, 1'b0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", longint'(bus.valid), 0);
        chk("midrst_bin", longint'(bus.bin), 0);
        chk("midrst_mag", longint'(bus.mag), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bus.ready = 1'b1;
        flush(2100, 0);
        rand_frame(1);
        send_frame(N, 1'b1, 0);
        flush(4, 0);
        wait_drain();

        chk("final_drops", longint'(drop_cnt), longint'(exp_drops));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fft_peak_finder.md
# fft_peak_finder

Downstream consumer of the 2048-point pipelined FFT core. Takes the bit-reversed, natural-order output stream (44-bit complex, 22-bit real in the high half and 22-bit imaginary in the low half, with a frame sync) and computes |X|² per bin. It tracks the largest magnitude inside a programmable bin window and, once per frame, presents the peak bin index and magnitude on a valid/ready output for the range/bearing logic.

## Interface
- IWIDTH, 22: width of each real/imag component of the input.
- LGSIZE, 11: log2 of FFT frame length (2048 bins).
- BIN_LO, 1: lowest bin searched (inclusive; default skips DC).
- BIN_HI, 1023: highest bin searched (inclusive; default covers positive frequencies only).
- i_clk  in  1  single clock; all logic on the rising edge.
- i_reset_n  in  1  reset, asynchronous and active-low.
- i_ce  in  1  sample strobe, same meaning as on the FFT core; the pipeline advances only when it is high.
- i_sync  in  1  high with the first bin (bin 0) of a frame; qualified by i_ce.
- i_result  in  2*IWIDTH  complex bin value, real [43:22], imag [21:0], two's complement.
- o_valid  out  1  peak result available.
- i_ready  in  1  consumer accepts the result when it is high together with o_valid.
- o_bin  out  LGSIZE  peak bin index.
- o_mag  out  2*IWIDTH  peak |X|² (re²+im²), unsigned.
- o_drop  out  1  one-cycle pulse: a frame result was lost because the output was still occupied.

## Operation
- Started flag: cleared by reset. Set on the first i_ce&&i_sync. All input is ignored until the flag is set.
- Bin counter: on i_ce, it loads 0 if i_sync is high; otherwise it increments modulo 2^LGSIZE. An early i_sync restarts the count at 0.
- Stage 1 (on i_ce): register re² and im². These are signed squares, so the result is non-negative and up to 2^42 each (the −2^21 case). The bin index and valid bit travel alongside.
- Stage 2 (on i_ce): register sum = re²+im². This is 2*IWIDTH bits and cannot overflow (max 2^43).
- Stage 3 (on i_ce): compare against the running best for the frame.
  - If stage-2 bin == 0: clear best and set the "empty" flag.
  - If the bin is in [BIN_LO, BIN_HI]:
    - If empty, or sum > best_mag (strict), load best_mag and best_bin, then clear empty.
    - Ties keep the lowest bin.
    - A frame of all-zero samples reports bin BIN_LO with magnitude 0.
  - If the bin == 2^LGSIZE−1: finalize the frame using best, including a same-cycle update from this bin if it is in the window.
- Finalize:
  - If o_valid==0, or o_valid&&i_ready in this cycle, load o_bin/o_mag and set o_valid.
  - Otherwise keep the old result, discard the new one, and pulse o_drop.
- A frame truncated by an early i_sync never reaches the last bin. Its best is cleared at the next bin 0 and it produces neither an output nor o_drop.
- Handshake:
  - o_valid stays high and o_bin/o_mag stay stable until a cycle with i_ready high.
  - o_valid falls on the edge after acceptance unless a finalize lands in that same cycle.
  - i_ready is independent of i_ce, and no backpressure reaches the FFT.

## Timing
- Reset (asynchronous assertion, synchronous deassertion at the integrating level) forces the following to 0 immediately:
  - o_valid, o_drop, o_bin, o_mag
  - the started flag, pipeline valids, the bin counter, best_mag, best_bin
- Reset in mid-frame discards everything. Output resumes only after the next full frame that begins with i_sync.
- Latency: the last bin is captured at i_ce edge E0, and o_valid is high after the 2nd subsequent i_ce edge (E2). With i_ce tied high, o_valid rises 3 clocks after the last bin is presented.
- o_drop is high for exactly one clock, the clock following the finalize edge.
- Throughput: one result per 2^LGSIZE i_ce strobes. The bubble between frames is zero.

## Structure
- Shared package fft_pkg holds:
  - LGSIZE, IWIDTH, MWIDTH (=2*IWIDTH)
  - a typedef for the complex input word
  - a typedef for the {bin, mag} result
- Sub-module cmag_sq: the 2-stage CE-gated complex magnitude-squared pipeline, carrying the valid and bin sideband. Comparator, window logic and output register stay in the top module.

## Test plan
- Single tone: frame with bin 300 = (1000, −1000) and all others 0, i_ready=1 → o_valid once, o_bin=300, o_mag=2,000,000, 3 clocks after bin 2047.
- Window and tie: equal magnitude 500² at bins 0, 40, 1500 and 40 again at bin 900 → o_bin=40 (DC and bin 1500 are outside the window, and the tie keeps the lowest bin).
- Full scale: bin 10 = (−2^21, −2^21) → o_mag = 2^43 exactly, with no wrap.
- Backpressure: i_ready=0 across two complete frames → first result held stable, o_drop pulses once at the second frame end. Raising i_ready then yields the first frame's result.
- Early sync: i_sync reasserted at bin 1000 of a frame whose peak is at 200; the next full frame has its peak at 700 → one output only, o_bin=700.
- Sparse CE and reset: i_ce high 1 in 3 clocks gives results identical to continuous CE. Asserting i_reset_n=0 mid-frame clears o_valid at once, and no output appears before the next synced frame.
